// File: rtl/fifo_stream_reader.sv
// Registered-read FIFO to valid/ready stream bridge with a 2-entry buffer and read credits.
// Latency: first word valid one edge after its read returns; backpressure holds data, stops reads at 2 outstanding.
module fifo_stream_reader #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]  rd_count,
  output logic              busy
);

  logic [1:0]        r_occ;
  logic              r_inflight;
  logic [DATA_W-1:0] r_buf0;
  logic [DATA_W-1:0] r_buf1;
  logic [CNT_W-1:0]  r_count;

  logic              w_pop;
  logic              w_cap;
  logic [2:0]        w_used;
  logic [2:0]        w_limit;
  logic              w_has_slot;
  logic [1:0]        w_occ_nxt;
  logic [DATA_W-1:0] w_buf0_nxt;
  logic [DATA_W-1:0] w_buf1_nxt;

  assign w_pop = (r_occ != 2'd0) & m_ready;
  assign w_cap = r_inflight & ~flush;

  // Words held or promised must stay at most 1 + this cycle's pop before issuing another read.
  assign w_used     = {1'b0, r_occ} + {2'b00, r_inflight};
  assign w_limit    = {2'b00, w_pop} + 3'd1;
  assign w_has_slot = (w_used <= w_limit);
  assign fifo_rd_en = ~rst & en & ~fifo_empty & ~flush & w_has_slot;

  always_comb begin
    w_occ_nxt  = r_occ;
    w_buf0_nxt = r_buf0;
    w_buf1_nxt = r_buf1;
    case (r_occ)
      2'd0: begin
        if (w_cap) begin
          w_buf0_nxt = fifo_rd_data;
          w_occ_nxt  = 2'd1;
        end
      end
      2'd1: begin
        if (w_pop && w_cap) begin
          w_buf0_nxt = fifo_rd_data;
        end else if (w_pop) begin
          w_occ_nxt = 2'd0;
        end else if (w_cap) begin
          w_buf1_nxt = fifo_rd_data;
          w_occ_nxt  = 2'd2;
        end
      end
      default: begin
        if (w_pop) begin
          w_buf0_nxt = r_buf1;
          if (w_cap) begin
            w_buf1_nxt = fifo_rd_data;
          end else begin
            w_occ_nxt = 2'd1;
          end
        end
      end
    endcase
    if (flush) begin
      w_occ_nxt = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_count    <= '0;
    end else begin
      r_occ      <= w_occ_nxt;
      r_inflight <= fifo_rd_en;
      r_buf0     <= w_buf0_nxt;
      r_buf1     <= w_buf1_nxt;
      if (w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign m_valid  = (r_occ != 2'd0);
  assign m_data   = r_buf0;
  assign rd_count = r_count;
  assign busy     = (r_occ != 2'd0) | r_inflight;

endmodule
